bp_table_ctrl: RTL and testbench
================================

BP_TABLE_CTRL -- requirements
Module: bp_table_ctrl

Interface
REQ-001 SHALL have parameters, one per line as name, default, meaning:
- IDX_W, 10, table index width; table depth is 2^IDX_W.
- FQ_DEPTH, 4, update queue entries.
- INIT_VAL, 2'b01, counter value written at init (weakly not-taken).

REQ-002 SHALL have ports, one per line as name, direction, width, meaning:
- clk, in, 1, single clock.
- rst, in, 1, asynchronous active-low reset.
- flush, in, 1, single-cycle re-init request.
- lk_valid, in, 1, IF lookup request.
- lk_pc, in, 32, IF fetch PC.
- lk_ready, out, 1, lookup accepted this cycle.
- lk_rsp_valid, out, 1, lookup result valid.
- lk_taken, out, 1, predicted taken.
- upd_valid, in, 1, ID resolved-branch update.
- upd_pc, in, 32, branch PC.
- upd_taken, in, 1, actual outcome.
- upd_ready, out, 1, update accepted.
- tbl_en, out, 1, table port enable.
- tbl_we, out, 1, table write enable.
- tbl_addr, out, IDX_W, table index.
- tbl_wdata, out, 2, write counter.
- tbl_rdata, in, 2, read counter, valid one cycle after read enable.
- init_done, out, 1, table initialised.

REQ-003 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 SHALL derive the table index as pc[IDX_W+1:2] for both lookup and update.

REQ-005 SHALL implement a three-state FSM:
- INIT: write INIT_VAL to index init_ptr each cycle (tbl_en=1, tbl_we=1); after index 2^IDX_W-1, go to IDLE.
- IDLE: port arbitration.
- UPD_WR: write back one update.

REQ-006 SHALL, in INIT, hold lk_ready=0 and init_done=0; init_done SHALL rise in the first IDLE cycle (INIT lasts exactly 2^IDX_W cycles).

REQ-007 SHALL queue updates in a FIFO of FQ_DEPTH entries holding {index, taken}, with upd_ready = !full; an update is accepted when upd_valid && upd_ready, in any state including INIT.

REQ-008 SHALL arbitrate in IDLE with the following priority:
- (a) FIFO full: issue a read of the head index and go to UPD_WR.
- (b) else if lk_valid: issue a read of the lookup index and set lk_ready=1.
- (c) else if FIFO non-empty: issue a read of the head index and go to UPD_WR.
- (d) else: tbl_en=0.

REQ-009 SHALL assert lk_rsp_valid exactly one cycle after lk_ready, with lk_taken = tbl_rdata[1]; lk_rsp_valid SHALL be 0 otherwise.

REQ-010 SHALL, in UPD_WR:
- write to the head index with tbl_wdata = tbl_rdata+1 if taken, else tbl_rdata-1, saturating at 3 and 0;
- pop the head;
- return to IDLE;
- hold lk_ready=0.

REQ-011 SHALL allow push and pop in the same cycle, leaving the count unchanged.

REQ-012 SHALL NOT forward queued updates to lookups; a lookup of an index with a pending update returns the stored value.

REQ-013 SHALL, on flush, in any state:
- clear the FIFO, discarding any in-flight UPD_WR (no write that cycle);
- drop any pending lk_rsp_valid;
- set init_ptr=0 and enter INIT next cycle;
- drive init_done low next cycle.
Flush during INIT restarts from index 0.

REQ-014 SHALL reject updates (upd_ready=0) in the flush cycle.

REQ-015 SHALL drive tbl_we=0 whenever tbl_en=0.

Reset
REQ-016 SHALL, while rst=0:
- force state to INIT with init_ptr=0 and an empty FIFO;
- drive lk_ready=0, lk_rsp_valid=0, lk_taken=0, upd_ready=0, tbl_en=0, tbl_we=0, tbl_addr=0, tbl_wdata=0, init_done=0.

REQ-017 SHALL begin INIT writes in the first clock edge after rst deasserts; upd_ready SHALL follow REQ-007 from that cycle.

Verification
REQ-018 Release reset -> 1024 writes of 2'b01 at addresses 0..1023, then init_done=1 at cycle 1024; a lookup then returns lk_taken=0.

REQ-019 Three updates, taken, on pc 0x100, then a lookup of pc 0x100 -> counter sequence 1->2->3->3, lk_taken=1 one cycle after lk_ready.

REQ-020 Four updates queued while lk_valid is held high -> FIFO full, upd_ready=0, next IDLE cycle serves an update, lk_ready=0 for 2 cycles, then lk_ready=1.

REQ-021 Counter at 0 with not-taken update -> writes 0; counter at 3 with taken update -> writes 3.

REQ-022 Flush asserted during UPD_WR with 2 entries queued -> no table write, FIFO empty, INIT restarts at address 0, init_done low.

REQ-023 Reset asserted mid-INIT at address 500 -> all outputs 0 immediately; after release, INIT restarts at address 0.

Source files
------------

// File: rtl/bp_table_ctrl.sv
// Branch-predictor 2-bit counter table controller: initialises an external
// single-port table, then arbitrates IF lookups against queued ID updates.
module bp_table_ctrl #(
    parameter int unsigned IDX_W    = 10,
    parameter int unsigned FQ_DEPTH = 4,
    parameter logic [1:0]  INIT_VAL = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             lk_valid,
    input  logic [31:0]      lk_pc,
    output logic             lk_ready,
    output logic             lk_rsp_valid,
    output logic             lk_taken,
    input  logic             upd_valid,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    output logic             upd_ready,
    output logic             tbl_en,
    output logic             tbl_we,
    output logic [IDX_W-1:0] tbl_addr,
    output logic [1:0]       tbl_wdata,
    input  logic [1:0]       tbl_rdata,
    output logic             init_done
);

    localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FQ_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_UPD_WR
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] init_ptr_q, init_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rsp_q, rsp_d;
    logic             init_done_q, init_done_d;

    logic [IDX_W-1:0] fq_idx_q [FQ_DEPTH];
    logic             fq_tkn_q [FQ_DEPTH];

    logic [IDX_W-1:0] lk_idx, upd_idx, head_idx;
    logic             head_tkn;
    logic             fq_full, fq_empty;
    logic             push, pop;
    logic [1:0]       sat_cnt;
    logic             unused_pc_bits;

    assign lk_idx   = lk_pc[IDX_W+1:2];
    assign upd_idx  = upd_pc[IDX_W+1:2];
    assign head_idx = fq_idx_q[rd_ptr_q];
    assign head_tkn = fq_tkn_q[rd_ptr_q];
    assign fq_full  = (count_q == CNT_W'(FQ_DEPTH));
    assign fq_empty = (count_q == '0);
    assign unused_pc_bits = ^{lk_pc[31:IDX_W+2], lk_pc[1:0], upd_pc[31:IDX_W+2], upd_pc[1:0]};

    always_comb begin
        sat_cnt = tbl_rdata;
        if (head_tkn) begin
            if (tbl_rdata != 2'b11) sat_cnt = tbl_rdata + 2'b01;
        end else if (tbl_rdata != 2'b00) begin
            sat_cnt = tbl_rdata - 2'b01;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_ptr_d  = init_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rsp_d       = 1'b0;
        init_done_d = init_done_q;
        tbl_en      = 1'b0;
        tbl_we      = 1'b0;
        tbl_addr    = '0;
        tbl_wdata   = '0;
        lk_ready    = 1'b0;
        pop         = 1'b0;
        upd_ready   = rst & ~flush & ~fq_full;
        push        = upd_valid & upd_ready;

        // Port outputs are gated by rst so they read zero while reset is held.
        if (rst && !flush) begin
            case (state_q)
                ST_INIT: begin
                    tbl_en     = 1'b1;
                    tbl_we     = 1'b1;
                    tbl_addr   = init_ptr_q;
                    tbl_wdata  = INIT_VAL;
                    init_ptr_d = init_ptr_q + IDX_W'(1);
                    if (init_ptr_q == '1) begin
                        state_d     = ST_IDLE;
                        init_done_d = 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (fq_full) begin
                        tbl_en   = 1'b1;
                        tbl_addr = head_idx;
                        state_d  = ST_UPD_WR;
                    end else if (lk_valid) begin
                        tbl_en   = 1'b1;
                        tbl_addr = lk_idx;
                        lk_ready = 1'b1;
                        rsp_d    = 1'b1;
                    end else if (!fq_empty) begin
                        tbl_en   = 1'b1;
                        tbl_addr = head_idx;
                        state_d  = ST_UPD_WR;
                    end
                end
                ST_UPD_WR: begin
                    tbl_en    = 1'b1;
                    tbl_we    = 1'b1;
                    tbl_addr  = head_idx;
                    tbl_wdata = sat_cnt;
                    pop       = 1'b1;
                    state_d   = ST_IDLE;
                end
                default: state_d = ST_INIT;
            endcase
        end

        if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        if (flush) begin
            state_d     = ST_INIT;
            init_ptr_d  = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            rsp_d       = 1'b0;
            init_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            init_ptr_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rsp_q       <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rsp_q       <= rsp_d;
            init_done_q <= init_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fq_idx_q[wr_ptr_q] <= upd_idx;
            fq_tkn_q[wr_ptr_q] <= upd_taken;
        end
    end

    assign lk_rsp_valid = rsp_q & ~flush;
    assign lk_taken     = lk_rsp_valid & tbl_rdata[1];
    assign init_done    = init_done_q;

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Scoreboard bench for bp_table_ctrl: behavioural table + update queue model,
// external table memory, directed scenarios followed by randomized traffic.
module tb_bp_table_ctrl;

    localparam int unsigned IDX_W    = 10;
    localparam int unsigned DEPTH    = 1 << IDX_W;
    localparam int unsigned FQ       = 4;
    localparam logic [1:0]  INIT_VAL = 2'b01;
    localparam longint unsigned PERIOD = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             lk_valid;
    logic [31:0]      lk_pc;
    logic             lk_ready, lk_rsp_valid, lk_taken;
    logic             upd_valid;
    logic [31:0]      upd_pc;
    logic             upd_taken;
    logic             upd_ready;
    logic             tbl_en, tbl_we;
    logic [IDX_W-1:0] tbl_addr;
    logic [1:0]       tbl_wdata;
    logic [1:0]       tbl_rdata;
    logic             init_done;

    bp_table_ctrl #(.IDX_W(IDX_W), .FQ_DEPTH(FQ), .INIT_VAL(INIT_VAL)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_ready(lk_ready),
        .lk_rsp_valid(lk_rsp_valid), .lk_taken(lk_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_ready(upd_ready),
        .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
        .tbl_rdata(tbl_rdata), .init_done(init_done)
    );

    always #5 clk = ~clk;

    // External single-port table: read data appears the cycle after the read.
    logic [1:0] tb_mem [DEPTH];
    always @(posedge clk) begin
        if (tbl_en) begin
            if (tbl_we) tb_mem[tbl_addr] <= tbl_wdata;
            else        tbl_rdata <= tb_mem[tbl_addr];
        end
    end

    typedef struct { int unsigned idx; logic tkn; } upd_t;
    typedef struct { longint unsigned t; logic tkn; } lk_t;

    upd_t exp_upd [$];
    lk_t  exp_lk  [$];
    int   ref_tbl [DEPTH];
    bit   exp_init, exp_done;
    int unsigned init_cnt;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input logic t);
        if (t) return (v >= 3) ? 3 : v + 1;
        return (v <= 0) ? 0 : v - 1;
    endfunction

    function automatic int unsigned pc_idx(input logic [31:0] pc);
        return (pc >> 2) % DEPTH;
    endfunction

    function automatic void model_reinit();
        exp_init = 1'b1;
        init_cnt = 0;
        exp_done = 1'b0;
        exp_upd.delete();
        for (int i = 0; i < int'(DEPTH); i++) ref_tbl[i] = int'(INIT_VAL);
    endfunction

    // Table-side monitor: init sequence, update write-back, handshakes.
    always @(negedge clk) begin
        bit   full_now;
        upd_t u;
        int   nv;
        int unsigned li;
        if (!rst) begin
            chk("rst_outputs_zero", {tbl_addr, tbl_wdata, lk_ready, lk_rsp_valid, lk_taken,
                                     upd_ready, tbl_en, tbl_we, init_done}, 0);
            model_reinit();
        end else if (flush) begin
            chk("flush_tbl_en", tbl_en, 0);
            chk("flush_upd_ready", upd_ready, 0);
            chk("flush_lk_ready", lk_ready, 0);
            model_reinit();
        end else begin
            full_now = (exp_upd.size() == FQ);
            chk("init_done", init_done, exp_done);
            chk("upd_ready", upd_ready, !full_now);
            if (tbl_we) chk("we_needs_en", tbl_en, 1);
            if (exp_init) begin
                chk("init_write", {tbl_en, tbl_we, tbl_wdata}, {2'b11, INIT_VAL});
                chk("init_addr", tbl_addr, init_cnt);
                chk("init_lk_ready", lk_ready, 0);
                init_cnt++;
                if (init_cnt == DEPTH) begin
                    exp_init = 1'b0;
                    exp_done = 1'b1;
                end
            end else begin
                if (tbl_we) begin
                    if (exp_upd.size() == 0) begin
                        chk("unexpected_write", tbl_we, 0);
                    end else begin
                        u  = exp_upd.pop_front();
                        nv = sat(ref_tbl[u.idx], u.tkn);
                        chk("upd_addr", tbl_addr, u.idx);
                        chk("upd_wdata", tbl_wdata, nv);
                        ref_tbl[u.idx] = nv;
                    end
                end
                if (lk_ready) begin
                    li = pc_idx(lk_pc);
                    chk("lk_ready_needs_valid", lk_valid, 1);
                    chk("lk_ready_while_full", lk_ready & full_now, 0);
                    chk("lk_read_port", {tbl_en, tbl_we, tbl_addr}, {2'b10, IDX_W'(li)});
                    exp_lk.push_back('{$time, ref_tbl[li] >= 2});
                end
            end
            if (upd_valid && upd_ready) exp_upd.push_back('{pc_idx(upd_pc), upd_taken});
        end
    end

    // Response monitor: pops one expectation per lk_rsp_valid.
    always @(negedge clk) begin
        lk_t e;
        if (!rst || flush) begin
            if (rst) chk("flush_rsp_dropped", lk_rsp_valid, 0);
            exp_lk.delete();
        end else if (lk_rsp_valid) begin
            if (exp_lk.size() == 0) begin
                chk("rsp_unexpected", lk_rsp_valid, 0);
            end else begin
                e = exp_lk.pop_front();
                chk("rsp_latency", $time - e.t, PERIOD);
                chk("rsp_taken", lk_taken, e.tkn);
            end
        end else if (exp_lk.size() > 0 && exp_lk[0].t + PERIOD <= $time) begin
            e = exp_lk.pop_front();
            chk("rsp_missing", lk_rsp_valid, 1);
        end
    end

    task automatic cyc_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        lk_valid  = 1'b0;
        upd_valid = 1'b0;
        flush     = 1'b0;
        repeat (n) cyc_step();
    endtask

    // Caller sits at the negedge of the first INIT cycle.
    task automatic wait_init(input string nm);
        int unsigned n = 0;
        while (!init_done && n < 3000) begin
            n++;
            @(negedge clk);
        end
        chk(nm, n, DEPTH);
        cyc_step();
    endtask

    task automatic send_upd(input logic [31:0] pc, input logic t);
        int n = 0;
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_taken = t;
        @(negedge clk);
        while (!upd_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("upd_accept", upd_ready, 1);
        cyc_step();
        upd_valid = 1'b0;
    endtask

    task automatic lookup_const(input string nm, input logic [31:0] pc, input logic t);
        lk_valid = 1'b1;
        lk_pc    = pc;
        @(negedge clk);
        chk({nm, "_ready"}, lk_ready, 1);
        cyc_step();
        lk_valid = 1'b0;
        @(negedge clk);
        chk(nm, {lk_rsp_valid, lk_taken}, {1'b1, t});
        cyc_step();
    endtask

    function automatic logic [31:0] rnd_pc();
        logic [31:0] pc;
        pc = $urandom();
        pc[IDX_W+1:2] = IDX_W'($urandom_range(0, 7));
        return pc;
    endfunction

    initial begin
        logic [1:0] saved;
        rst = 1'b0; flush = 1'b0; lk_valid = 1'b0; lk_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; tbl_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("first_init_addr", {tbl_we, tbl_addr}, {1'b1, IDX_W'(0)});
        wait_init("init_cycles");
        lookup_const("lk_after_init", 32'h0000_1234, 1'b0);

        repeat (3) send_upd(32'h100, 1'b1);
        drain(6);
        chk("ctr_sat_high", tb_mem[64], 3);
        lookup_const("lk_pc100", 32'h100, 1'b1);

        repeat (3) send_upd(32'h200, 1'b0);
        drain(6);
        chk("ctr_sat_low", tb_mem[128], 0);
        lookup_const("lk_pc200", 32'h200, 1'b0);

        // Fill the queue under continuous lookup pressure.
        drain(2);
        lk_valid = 1'b1;
        lk_pc    = 32'h100;
        for (int k = 0; k < 4; k++) begin
            upd_valid = 1'b1;
            upd_pc    = 32'h300 + 32'(k * 4);
            upd_taken = k[0];
            @(negedge clk);
            chk("fill_lk_ready", lk_ready, 1);
            cyc_step();
        end
        upd_valid = 1'b0;
        @(negedge clk);
        chk("full_upd_ready", upd_ready, 0);
        chk("full_lk_ready_c0", lk_ready, 0);
        cyc_step();
        @(negedge clk);
        chk("full_lk_ready_c1", lk_ready, 0);
        cyc_step();
        @(negedge clk);
        chk("full_lk_ready_c2", lk_ready, 1);
        cyc_step();
        drain(12);

        // Flush landing on an update write-back with two entries queued.
        saved = tb_mem[256];
        upd_valid = 1'b1; upd_pc = 32'h400; upd_taken = 1'b1;
        cyc_step();
        upd_pc = 32'h404;
        cyc_step();
        upd_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_no_write", tbl_we, 0);
        cyc_step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_restart", {tbl_en, tbl_we, tbl_addr, init_done}, {2'b11, IDX_W'(0), 1'b0});
        chk("flush_mem_kept", tb_mem[256], saved);
        wait_init("init_cycles_after_flush");

        // Reset asserted mid-INIT.
        flush = 1'b1;
        cyc_step();
        flush = 1'b0;
        repeat (500) cyc_step();
        @(negedge clk);
        chk("pre_rst_addr", tbl_addr, 500);
        #2 rst = 1'b0;
        #1 chk("rst_async_zero", {tbl_addr, tbl_wdata, lk_ready, lk_rsp_valid, lk_taken,
                                   upd_ready, tbl_en, tbl_we, init_done}, 0);
        repeat (2) cyc_step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_restart_addr", {tbl_we, tbl_addr}, {1'b1, IDX_W'(0)});
        wait_init("init_cycles_after_rst");

        for (int i = 0; i < 3000; i++) begin
            lk_valid  = 1'($urandom_range(0, 1));
            lk_pc     = rnd_pc();
            upd_valid = ($urandom_range(0, 99) < 40);
            upd_pc    = rnd_pc();
            upd_taken = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 999) == 0);
            cyc_step();
        end
        drain(1100);
        chk("queue_drained", exp_upd.size(), 0);
        chk("rsp_drained", exp_lk.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
